ldpc_layer_sched: RTL and testbench



---
 rtl/ldpc_layer_sched_pkg.sv | 25 ++
 rtl/ldpc_sched_delay.sv | 42 ++++
 rtl/ldpc_layer_sched.sv | 188 ++++++++++++++++++
 tb/tb_ldpc_layer_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ldpc_layer_sched_pkg.sv
// Shared types and width helpers for the layered min-sum decode sequencer.
package ldpc_layer_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MIN  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // clog2 that never returns zero, so every derived vector has at least one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned layers, input int unsigned deg);
    return clog2_min1(layers * deg);
  endfunction

  function automatic int unsigned iter_w(input int unsigned max_iter);
    return clog2_min1(max_iter + 1);
  endfunction

endpackage

// File: rtl/ldpc_sched_delay.sv
// Read-latency delay line for issued column indices; decodes to one-hot lane loads.
module ldpc_sched_delay
  import ldpc_layer_sched_pkg::*;
#(
  parameter int unsigned DEG    = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned COL_W  = clog2_min1(DEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [COL_W-1:0] in_col,
  output logic [DEG-1:0]   load_temp
);

  logic [RD_LAT-1:0] vld_q;
  logic [COL_W-1:0]  col_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) col_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) col_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      col_q[0] <= in_col;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        col_q[i] <= col_q[i-1];
      end
    end
  end

  always_comb begin
    load_temp = '0;
    if (vld_q[RD_LAT-1]) load_temp[col_q[RD_LAT-1]] = 1'b1;
  end

endmodule

// File: rtl/ldpc_layer_sched.sv
// Layered min-sum pass sequencer: per layer RD -> MIN -> WR, iterating until
// convergence or the iteration cap.
module ldpc_layer_sched
  import ldpc_layer_sched_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned DEG        = 8,
  parameter int unsigned MAX_ITER   = 10,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MIN_LAT    = 2,
  parameter int unsigned ADDR_W     = addr_w(NUM_LAYERS, DEG),
  parameter int unsigned ITER_W     = iter_w(MAX_ITER),
  parameter int unsigned LAYER_W    = clog2_min1(NUM_LAYERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               syndrome_ok,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [DEG-1:0]     load_temp,
  output logic               min_start,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               busy,
  output logic               done,
  output logic               converged
);

  localparam int unsigned RD_LEN = DEG + RD_LAT;
  localparam int unsigned K_MAX  = (RD_LEN > MIN_LAT) ? RD_LEN : MIN_LAT;
  localparam int unsigned K_W    = clog2_min1(K_MAX);
  localparam int unsigned COL_W  = clog2_min1(DEG);

  localparam logic [K_W-1:0]     K_RD_LAST  = K_W'(RD_LEN - 1);
  localparam logic [K_W-1:0]     K_MIN_LAST = K_W'(MIN_LAT - 1);
  localparam logic [K_W-1:0]     K_WR_LAST  = K_W'(DEG - 1);
  localparam logic [K_W-1:0]     K_DEG      = K_W'(DEG);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [ITER_W-1:0]  ITER_MAX   = ITER_W'(MAX_ITER);
  localparam logic [ADDR_W-1:0]  DEG_A      = ADDR_W'(DEG);

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [LAYER_W-1:0] layer_d;
  logic [ITER_W-1:0]  iter_d;
  logic               conv_d;
  logic               halt_act;
  logic               rd_en_d, wr_en_d, min_start_d;
  logic [ADDR_W-1:0]  rd_addr_d, wr_addr_d;
  logic [COL_W-1:0]   rd_col, rd_col_d;

  assign halt_act = halt && (state_q != ST_IDLE);

  // Next state, counters, and the values every output register takes next
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    layer_d     = layer_idx;
    iter_d      = iter_cnt;
    conv_d      = converged;
    rd_en_d     = 1'b0;
    rd_addr_d   = '0;
    rd_col_d    = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    min_start_d = 1'b0;

    if (halt_act) begin
      state_d = ST_IDLE;
      k_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !halt) begin
            state_d = ST_RD;
            k_d     = '0;
            layer_d = '0;
            iter_d  = '0;
            conv_d  = 1'b0;
          end
        end
        ST_RD: begin
          if (k_q == K_RD_LAST) begin
            state_d = ST_MIN;
            k_d     = '0;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        ST_MIN: begin
          if (k_q == K_MIN_LAST) begin
            state_d = ST_WR;
            k_d     = '0;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        ST_WR: begin
          if (k_q == K_WR_LAST) begin
            k_d = '0;
            if (layer_idx != LAYER_LAST) begin
              layer_d = layer_idx + LAYER_W'(1);
              state_d = ST_RD;
            end else begin
              layer_d = '0;
              iter_d  = (iter_cnt == ITER_MAX) ? iter_cnt : iter_cnt + ITER_W'(1);
              if (syndrome_ok) begin
                conv_d  = 1'b1;
                state_d = ST_DONE;
              end else if (iter_d == ITER_MAX) begin
                conv_d  = 1'b0;
                state_d = ST_DONE;
              end else begin
                state_d = ST_RD;
              end
            end
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Strobes follow the next state so they align with it cycle for cycle
    if (state_d == ST_RD && k_d < K_DEG) begin
      rd_en_d   = 1'b1;
      rd_addr_d = ADDR_W'(layer_d) * DEG_A + ADDR_W'(k_d);
      rd_col_d  = COL_W'(k_d);
    end
    if (state_d == ST_WR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ADDR_W'(layer_d) * DEG_A + ADDR_W'(k_d);
    end
    min_start_d = (state_d == ST_MIN) && (k_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      layer_idx <= '0;
      iter_cnt  <= '0;
      converged <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_col    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      min_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      layer_idx <= layer_d;
      iter_cnt  <= iter_d;
      converged <= conv_d;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      rd_en     <= rd_en_d;
      rd_addr   <= rd_addr_d;
      rd_col    <= rd_col_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      min_start <= min_start_d;
    end
  end

  ldpc_sched_delay #(
    .DEG    (DEG),
    .RD_LAT (RD_LAT),
    .COL_W  (COL_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (halt_act),
    .in_valid  (rd_en),
    .in_col    (rd_col),
    .load_temp (load_temp)
  );

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// Directed and randomised checks of the layer sequencer at DEG=4, 2 layers, 3 iterations.
module tb_ldpc_layer_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       syndrome_ok = 1'b0;
  logic       rd_en, wr_en, min_start, busy, done, converged;
  logic [2:0] rd_addr, wr_addr;
  logic [3:0] load_temp;
  logic [0:0] layer_idx;
  logic [1:0] iter_cnt;

  int checks = 0;
  int failures = 0;

  localparam int CPL = 11;

  ldpc_layer_sched #(
    .NUM_LAYERS (2),
    .DEG        (4),
    .MAX_ITER   (3),
    .RD_LAT     (1),
    .MIN_LAT    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .syndrome_ok (syndrome_ok),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .load_temp   (load_temp),
    .min_start   (min_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .layer_idx   (layer_idx),
    .iter_cnt    (iter_cnt),
    .busy        (busy),
    .done        (done),
    .converged   (converged)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Addresses only matter while their strobe is high
  function automatic logic [31:0] obs_vec();
    return 32'({rd_en, (rd_en ? rd_addr : 3'd0), load_temp, min_start, wr_en,
                (wr_en ? wr_addr : 3'd0), busy, done, layer_idx, iter_cnt});
  endfunction

  function automatic logic [31:0] obs_strb();
    return 32'({rd_en, load_temp, min_start, wr_en, busy, done});
  endfunction

  // Expected outputs for work cycle w of a run (layer = 11 cycles: RD 5, MIN 2, WR 4)
  function automatic logic [31:0] exp_vec(input int w);
    int         lay, pos, layer;
    logic       rd, ms, we;
    logic [2:0] ra, wa;
    logic [3:0] lt;
    lay   = w / CPL;
    pos   = w % CPL;
    layer = lay % 2;
    rd    = (pos < 4);
    ra    = rd ? 3'(layer * 4 + pos) : 3'd0;
    lt    = 4'd0;
    if (pos >= 1 && pos <= 4) lt = 4'(1 << (pos - 1));
    ms    = (pos == 5);
    we    = (pos >= 7);
    wa    = we ? 3'(layer * 4 + pos - 7) : 3'd0;
    return 32'({rd, ra, lt, ms, we, wa, 1'b1, 1'b0, 1'(layer), 2'(lay / 2)});
  endfunction

  // One run from a start pulse; syndrome_ok held from iteration syn_iter (0 = never)
  task automatic run_decode(input int syn_iter, input int layers, input bit exp_conv,
                            input int halt_w, input int start_w);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int w = 0; w < layers * CPL; w++) begin
      check("strobes", obs_vec(), exp_vec(w));
      syndrome_ok = (syn_iter > 0) && (w >= (syn_iter - 1) * 2 * CPL);
      start       = (w == start_w);
      halt        = (w == halt_w);
      @(negedge clk);
      if (w == halt_w) begin
        halt = 1'b0;
        start = 1'b0;
        check("halt_idle", obs_strb(), 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("halt_no_done", obs_strb(), 32'd0);
        end
        return;
      end
    end
    start = 1'b0;
    syndrome_ok = 1'b0;
    check("done_vec", obs_vec(), 32'({10'd0, 3'd0, 1'b1, 1'b1, 1'b0, 2'(layers / 2)}));
    check("converged", 32'(converged), 32'(exp_conv));
    @(negedge clk);
    check("idle_after", obs_strb(), 32'd0);
    check("conv_hold", 32'(converged), 32'(exp_conv));
  endtask

  logic [3:0] acc;
  int         cnt;
  logic       prev_rd, prev_wr, prev_done;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_strb", obs_strb(), 32'd0);
    check("rst_cnt", 32'({layer_idx, iter_cnt, converged}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle", obs_strb(), 32'd0);

    // start and halt together in IDLE: stay idle
    start = 1'b1; halt = 1'b1;
    @(negedge clk);
    start = 1'b0; halt = 1'b0;
    check("start_halt_idle", 32'(busy), 32'd0);

    // Nominal: three iterations, no convergence, start pulsed while busy
    run_decode(0, 6, 1'b0, -1, 30);

    // Halt in the first WR cycle of layer 1, iteration 1; then a clean restart
    run_decode(0, 6, 1'b0, 18, -1);
    run_decode(0, 6, 1'b0, -1, -1);

    // Halt mid-RD must leave no stale lane load
    run_decode(0, 6, 1'b0, 2, -1);

    // Early convergence in iteration 2
    run_decode(2, 4, 1'b1, -1, -1);

    // Asynchronous reset mid-RD of layer 1, iteration 2
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int w = 0; w < 34; w++) @(negedge clk);
    check("pre_rst_layer", 32'({layer_idx, iter_cnt}), 32'({1'b1, 2'd1}));
    #2 rst = 1'b1;
    #1;
    check("async_rst_strb", obs_strb(), 32'd0);
    check("async_rst_cnt", 32'({layer_idx, iter_cnt, converged}), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_stays_idle", obs_strb(), 32'd0);
    end

    // Randomised halt/start/syndrome_ok with invariant checks
    acc = 4'd0; cnt = 0; prev_rd = 1'b0; prev_wr = 1'b0; prev_done = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      start       = ($urandom_range(0, 9) == 0);
      halt        = ($urandom_range(0, 149) == 0);
      syndrome_ok = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      check("rdwr_excl", 32'(rd_en & wr_en), 32'd0);
      check("lt_onehot0", 32'($onehot0(load_temp)), 32'd1);
      check("done_src", 32'(done & ~(prev_wr & ~prev_done)), 32'd0);
      if (rd_en && !prev_rd) begin
        acc = 4'd0;
        cnt = 0;
      end
      acc = acc | load_temp;
      cnt = cnt + $countones(load_temp);
      if (min_start) check("lane_cover", 32'({cnt[7:0], acc}), 32'({8'd4, 4'hf}));
      prev_rd   = rd_en;
      prev_wr   = wr_en;
      prev_done = done;
    end
    start = 1'b0; halt = 1'b1; syndrome_ok = 1'b0;
    @(negedge clk);
    halt = 1'b0;
    @(negedge clk);
    check("final_idle", obs_strb(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
